// File: rtl/dco_fll_pkg.sv
// Shared types and helpers for the DCO frequency-locked-loop controller.
// Holds the FSM state encoding, default widths and the saturating code step.
package dco_fll_pkg;

    localparam int NBIT_DEF  = 13;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAR_MEAS = 3'd1,
        ST_SAR_WAIT = 3'd2,
        ST_TRK_MEAS = 3'd3,
        ST_TRK_WAIT = 3'd4
    } fll_state_t;

    // Width-agnostic +/-1 step clamped to [0, code_max]; callers cast back to the code width.
    function automatic logic [31:0] sat_step(
        input logic [31:0] code,
        input logic        dir,
        input logic [31:0] code_max
    );
        logic [31:0] res;
        if (dir) begin
            res = (code >= code_max) ? code_max : code + 32'd1;
        end else begin
            res = (code == 32'd0) ? 32'd0 : code - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dco_fll_err.sv
// Frequency-error classifier: compares a measured DCO edge count against the target
// and reports whether it lies inside the +/-LOCK_TOL deadband or above/below it.
module dco_fll_err #(
    parameter int CNT_W    = 16,
    parameter int LOCK_TOL = 2
) (
    input  logic [CNT_W-1:0] i_cnt_val,
    input  logic [CNT_W-1:0] i_target_cnt,
    output logic             o_in_tol,
    output logic             o_err_pos,
    output logic             o_err_neg
);

    localparam logic signed [CNT_W:0] TOL = (CNT_W+1)'(LOCK_TOL);

    // One extra bit lets the difference of two unsigned counts be represented without overflow.
    logic signed [CNT_W:0] w_err;

    assign w_err     = $signed({1'b0, i_cnt_val}) - $signed({1'b0, i_target_cnt});
    assign o_err_pos = (w_err > TOL);
    assign o_err_neg = (w_err < -TOL);
    assign o_in_tol  = ~o_err_pos & ~o_err_neg;

endmodule

// File: rtl/dco_fll_ctrl.sv
// FLL controller for an exponential DCO: SAR acquisition of the code, then bang-bang tracking with lock detect.
// Optional macro FLL_RELOCK_EN: re-run acquisition after RELOCK_N consecutive out-of-tolerance windows.
module dco_fll_ctrl
    import dco_fll_pkg::*;
#(
    parameter int Nbit     = NBIT_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 4
`ifdef FLL_RELOCK_EN
   ,parameter int RELOCK_N = 3
`endif
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_valid,
    output logic             meas_start,
    output logic [Nbit-1:0]  dco_code,
    output logic             busy,
    output logic             locked,
    output logic             lock_lost
);

    localparam int IDX_W = (Nbit > 1) ? $clog2(Nbit) : 1;
    localparam int LC_W  = $clog2(LOCK_CNT + 1);

    localparam logic [Nbit-1:0]  CODE_MID = Nbit'(1) << (Nbit - 1);
    localparam logic [Nbit-1:0]  CODE_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(Nbit - 1);
    localparam logic [LC_W-1:0]  LC_MAX   = LC_W'(LOCK_CNT);

`ifdef FLL_RELOCK_EN
    localparam int RUN_W = $clog2(RELOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RELOCK_N);
`endif

    fll_state_t       r_state;
    fll_state_t       w_state_nxt;
    logic [Nbit-1:0]  r_code;
    logic [Nbit-1:0]  w_code_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [LC_W-1:0]  r_lock_cnt;
    logic [LC_W-1:0]  w_lock_cnt_nxt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             r_lock_lost;
    logic             w_lock_lost_nxt;

    logic             w_in_tol;
    logic             w_err_pos;
    logic             w_err_neg;

`ifdef FLL_RELOCK_EN
    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_cnt_nxt;
    logic [RUN_W-1:0] w_run_inc;
    logic             r_ever_locked;
    logic             w_ever_locked_nxt;

    assign w_run_inc = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + RUN_W'(1);
`endif

    dco_fll_err #(
        .CNT_W    (CNT_W),
        .LOCK_TOL (LOCK_TOL)
    ) u_err (
        .i_cnt_val    (cnt_val),
        .i_target_cnt (target_cnt),
        .o_in_tol     (w_in_tol),
        .o_err_pos    (w_err_pos),
        .o_err_neg    (w_err_neg)
    );

    // NOTE: every next-value signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_idx_nxt       = r_idx;
        w_lock_cnt_nxt  = r_lock_cnt;
        w_locked_nxt    = r_locked;
        w_lock_lost_nxt = 1'b0;
`ifdef FLL_RELOCK_EN
        w_run_cnt_nxt     = r_run_cnt;
        w_ever_locked_nxt = r_ever_locked;
`endif

        if (stop) begin
            // Abort wins over a coincident measurement; the code is left where it was.
            w_state_nxt    = ST_IDLE;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
`ifdef FLL_RELOCK_EN
            w_run_cnt_nxt     = '0;
            w_ever_locked_nxt = 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt    = ST_SAR_MEAS;
                        w_code_nxt     = CODE_MID;
                        w_idx_nxt      = IDX_TOP;
                        w_lock_cnt_nxt = '0;
`ifdef FLL_RELOCK_EN
                        w_run_cnt_nxt     = '0;
                        w_ever_locked_nxt = 1'b0;
`endif
                    end
                end

                ST_SAR_MEAS: w_state_nxt = ST_SAR_WAIT;

                ST_SAR_WAIT: begin
                    if (cnt_valid) begin
                        if (cnt_val > target_cnt) begin
                            w_code_nxt[r_idx] = 1'b0;
                        end
                        if (r_idx != '0) begin
                            w_code_nxt[r_idx - IDX_W'(1)] = 1'b1;
                            w_idx_nxt   = r_idx - IDX_W'(1);
                            w_state_nxt = ST_SAR_MEAS;
                        end else begin
                            w_state_nxt = ST_TRK_MEAS;
                        end
                    end
                end

                ST_TRK_MEAS: w_state_nxt = ST_TRK_WAIT;

                ST_TRK_WAIT: begin
                    if (cnt_valid) begin
                        w_state_nxt = ST_TRK_MEAS;
                        if (w_err_pos) begin
                            w_code_nxt     = Nbit'(sat_step(32'(r_code), 1'b0, 32'(CODE_MAX)));
                            w_lock_cnt_nxt = '0;
                        end else if (w_err_neg) begin
                            w_code_nxt     = Nbit'(sat_step(32'(r_code), 1'b1, 32'(CODE_MAX)));
                            w_lock_cnt_nxt = '0;
                        end else if (r_lock_cnt != LC_MAX) begin
                            w_lock_cnt_nxt = r_lock_cnt + LC_W'(1);
                        end
                        w_locked_nxt    = (w_lock_cnt_nxt == LC_MAX);
                        w_lock_lost_nxt = r_locked & ~w_in_tol;
`ifdef FLL_RELOCK_EN
                        if (w_locked_nxt) begin
                            w_ever_locked_nxt = 1'b1;
                        end
                        if (w_in_tol) begin
                            w_run_cnt_nxt = '0;
                        end else if (r_ever_locked && (w_run_inc == RUN_MAX)) begin
                            // Sustained loss of lock: restart acquisition from mid-scale, no tracking step.
                            w_state_nxt   = ST_SAR_MEAS;
                            w_code_nxt    = CODE_MID;
                            w_idx_nxt     = IDX_TOP;
                            w_run_cnt_nxt = '0;
                        end else begin
                            w_run_cnt_nxt = w_run_inc;
                        end
`endif
                    end
                end

                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_code      <= CODE_MID;
            r_idx       <= '0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_idx       <= w_idx_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_locked    <= w_locked_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

`ifdef FLL_RELOCK_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_run_cnt     <= '0;
            r_ever_locked <= 1'b0;
        end else begin
            r_run_cnt     <= w_run_cnt_nxt;
            r_ever_locked <= w_ever_locked_nxt;
        end
    end
`endif

    assign meas_start = (r_state == ST_SAR_MEAS) || (r_state == ST_TRK_MEAS);
    assign busy       = (r_state != ST_IDLE);
    assign dco_code   = r_code;
    assign locked     = r_locked;
    assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Directed bench for dco_fll_ctrl with a linear DCO/counter model (count = code + offset, 3 clk latency).
// Relock expectations follow the FLL_RELOCK_EN macro as seen by this file.
module tb_dco_fll_ctrl;

    localparam int NBIT  = 13;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] target_cnt = '0;
    logic [CNT_W-1:0] cnt_val = '0;
    logic             cnt_valid = 1'b0;
    logic             meas_start;
    logic [NBIT-1:0]  dco_code;
    logic             busy;
    logic             locked;
    logic             lock_lost;

    int errors = 0;
    int checks = 0;
    int ll_seen = 0;
    int meas_seen = 0;
    int m_offset = 0;
    int m_delay = 0;
    logic [CNT_W-1:0] m_val = '0;

    dco_fll_ctrl dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .stop       (stop),
        .target_cnt (target_cnt),
        .cnt_val    (cnt_val),
        .cnt_valid  (cnt_valid),
        .meas_start (meas_start),
        .dco_code   (dco_code),
        .busy       (busy),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] model_cnt(input logic [NBIT-1:0] code, input int off);
        int v;
        v = int'(code) + off;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return CNT_W'(v);
    endfunction

    // Counter model: latch the count when meas_start is seen, return it 3 clocks later.
    always @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            m_delay   = 0;
            cnt_valid = 1'b0;
        end else begin
            cnt_valid = 1'b0;
            if (m_delay > 0) begin
                m_delay--;
                if (m_delay == 0) begin
                    cnt_valid = 1'b1;
                    cnt_val   = m_val;
                end
            end
            if (meas_start === 1'b1) begin
                m_val   = model_cnt(dco_code, m_offset);
                m_delay = 3;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1;
        if (lock_lost === 1'b1) ll_seen++;
        if (meas_start === 1'b1) meas_seen++;
    endtask

    task automatic wait_meas(input int n, input string tag);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 20 * n + 20) begin
            tick();
            cyc++;
            if (meas_start === 1'b1) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: saw %0d meas_start pulses, wanted %0d", tag, seen, n);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        int m0;
        rstb = 1'b0;
        tick();
        checks++; if (dco_code !== 13'd4096) begin errors++; $display("FAIL rst_code: got %0d want 4096", dco_code); end
        checks++; if ({busy, meas_start, locked, lock_lost} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags: got busy/meas/locked/lost=%b want 0000", {busy, meas_start, locked, lock_lost}); end
        rstb = 1'b1;
        m0 = meas_seen;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (meas_seen !== m0 || busy !== 1'b0) begin errors++;
            $display("FAIL rst_idle: got meas=%0d busy=%b want 0 meas, busy 0", meas_seen - m0, busy); end
    endtask

    task automatic test_acquire();
        int ll0;
        ll0 = ll_seen;
        target_cnt = 16'd1000;
        m_offset = 0;
        start = 1'b1;
        wait_meas(1, "acq");
        checks++; if (dco_code !== 13'd4096) begin errors++; $display("FAIL acq_m1: got %0d want 4096", dco_code); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL acq_busy: got %b want 1", busy); end
        wait_meas(1, "acq");
        checks++; if (dco_code !== 13'd2048) begin errors++; $display("FAIL acq_m2: got %0d want 2048", dco_code); end
        wait_meas(1, "acq");
        checks++; if (dco_code !== 13'd1024) begin errors++; $display("FAIL acq_m3: got %0d want 1024", dco_code); end
        start = 1'b1;
        wait_meas(1, "acq");
        checks++; if (dco_code !== 13'd512) begin errors++; $display("FAIL acq_start_ignored_m4: got %0d want 512", dco_code); end
        wait_meas(9, "acq");
        checks++; if (dco_code !== 13'd1001) begin errors++; $display("FAIL acq_m13: got %0d want 1001", dco_code); end
        wait_meas(1, "acq");
        checks++; if (dco_code !== 13'd1000) begin errors++; $display("FAIL acq_trk_entry: got %0d want 1000", dco_code); end
        wait_meas(3, "acq");
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_not_yet_locked: got %b want 0", locked); end
        wait_meas(1, "acq");
        checks++; if (locked !== 1'b1 || dco_code !== 13'd1000) begin errors++;
            $display("FAIL acq_locked: got locked=%b code=%0d want 1, 1000", locked, dco_code); end
        checks++; if (ll_seen !== ll0) begin errors++; $display("FAIL acq_no_lost: got %0d pulses want 0", ll_seen - ll0); end
    endtask

    task automatic test_deadband();
        int ll0;
        ll0 = ll_seen;
        m_offset = 5;
        wait_meas(1, "db");
        checks++; if (dco_code !== 13'd1000 || locked !== 1'b1) begin errors++;
            $display("FAIL db_w0: got code=%0d locked=%b want 1000, 1", dco_code, locked); end
        wait_meas(1, "db");
        checks++; if (dco_code !== 13'd999 || locked !== 1'b0 || lock_lost !== 1'b1) begin errors++;
            $display("FAIL db_w1: got code=%0d locked=%b lost=%b want 999, 0, 1", dco_code, locked, lock_lost); end
        wait_meas(1, "db");
        checks++; if (dco_code !== 13'd998 || lock_lost !== 1'b0) begin errors++;
            $display("FAIL db_w2: got code=%0d lost=%b want 998, 0", dco_code, lock_lost); end
        wait_meas(1, "db");
        checks++; if (dco_code !== 13'd997) begin errors++; $display("FAIL db_w3: got %0d want 997", dco_code); end
        wait_meas(3, "db");
        checks++; if (dco_code !== 13'd997 || locked !== 1'b0) begin errors++;
            $display("FAIL db_hold: got code=%0d locked=%b want 997, 0", dco_code, locked); end
        wait_meas(1, "db");
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL db_relocked: got %b want 1", locked); end
        checks++; if (ll_seen - ll0 !== 1) begin errors++; $display("FAIL db_lost_count: got %0d want 1", ll_seen - ll0); end
    endtask

    task automatic test_saturation();
        int ll0;
        ll0 = ll_seen;
        stop = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || locked !== 1'b0 || dco_code !== 13'd997) begin errors++;
            $display("FAIL sat_stop: got busy=%b locked=%b code=%0d want 0, 0, 997", busy, locked, dco_code); end
        drain();
        checks++; if (ll_seen !== ll0) begin errors++; $display("FAIL sat_stop_no_lost: got %0d want 0", ll_seen - ll0); end
        m_offset = 0;
        target_cnt = 16'd0;
        start = 1'b1;
        wait_meas(14, "sat");
        checks++; if (dco_code !== 13'd0) begin errors++; $display("FAIL sat_low_sar: got %0d want 0", dco_code); end
        wait_meas(4, "sat");
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_low_locked: got %b want 1", locked); end
        m_offset = 10;
        wait_meas(2, "sat");
        checks++; if (dco_code !== 13'd0 || locked !== 1'b0) begin errors++;
            $display("FAIL sat_low_clamp: got code=%0d locked=%b want 0, 0", dco_code, locked); end
        target_cnt = 16'd9000;
        m_offset = 0;
        for (int k = 1; k <= 3; k++) begin
            wait_meas(1, "sat");
            checks++; if (dco_code !== NBIT'(k)) begin errors++; $display("FAIL sat_step_up: got %0d want %0d", dco_code, k); end
        end
        stop = 1'b1;
        tick();
        drain();
        start = 1'b1;
        wait_meas(2, "sat");
        checks++; if (dco_code !== 13'd6144) begin errors++; $display("FAIL sat_high_m2: got %0d want 6144", dco_code); end
        wait_meas(12, "sat");
        checks++; if (dco_code !== 13'd8191) begin errors++; $display("FAIL sat_high_sar: got %0d want 8191", dco_code); end
        for (int k = 0; k < 3; k++) begin
            wait_meas(1, "sat");
            checks++; if (dco_code !== 13'd8191 || locked !== 1'b0) begin errors++;
                $display("FAIL sat_high_clamp: got code=%0d locked=%b want 8191, 0", dco_code, locked); end
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        int m0;
        int ll0;
        stop = 1'b1;
        tick();
        drain();
        ll0 = ll_seen;
        target_cnt = 16'd1000;
        start = 1'b1;
        wait_meas(6, "abort");
        checks++; if (dco_code !== 13'd896) begin errors++; $display("FAIL abort_bit7_code: got %0d want 896", dco_code); end
        while (cnt_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        checks++; if (cnt_valid !== 1'b1) begin errors++; $display("FAIL abort_valid_timeout: got %b want 1", cnt_valid); end
        stop = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || dco_code !== 13'd896 || locked !== 1'b0) begin errors++;
            $display("FAIL abort_state: got busy=%b code=%0d locked=%b want 0, 896, 0", busy, dco_code, locked); end
        m0 = meas_seen;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (meas_seen !== m0 || dco_code !== 13'd896 || ll_seen !== ll0) begin errors++;
            $display("FAIL abort_quiet: got meas=%0d code=%0d lost=%0d want 0, 896, 0", meas_seen - m0, dco_code, ll_seen - ll0); end
    endtask

    task automatic test_reset_midop();
        int m0;
        int ll0;
        target_cnt = 16'd1000;
        m_offset = 0;
        start = 1'b1;
        wait_meas(18, "rmid");
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_locked: got %b want 1", locked); end
        tick();
        rstb = 1'b0;
        #2;
        checks++; if (dco_code !== 13'd4096 || locked !== 1'b0 || busy !== 1'b0 || meas_start !== 1'b0) begin errors++;
            $display("FAIL rmid_async: got code=%0d locked=%b busy=%b meas=%b want 4096, 0, 0, 0", dco_code, locked, busy, meas_start); end
        tick();
        rstb = 1'b1;
        m0 = meas_seen;
        ll0 = ll_seen;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (meas_seen !== m0 || ll_seen !== ll0 || busy !== 1'b0 || dco_code !== 13'd4096) begin errors++;
            $display("FAIL rmid_quiet: got meas=%0d lost=%0d busy=%b code=%0d want 0, 0, 0, 4096", meas_seen - m0, ll_seen - ll0, busy, dco_code); end
    endtask

    task automatic test_relock();
        int ll0;
        target_cnt = 16'd1000;
        m_offset = 0;
        start = 1'b1;
        wait_meas(18, "rl");
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rl_locked: got %b want 1", locked); end
        ll0 = ll_seen;
        m_offset = 50;
        wait_meas(2, "rl");
        checks++; if (dco_code !== 13'd999 || lock_lost !== 1'b1) begin errors++;
            $display("FAIL rl_w1: got code=%0d lost=%b want 999, 1", dco_code, lock_lost); end
        wait_meas(1, "rl");
        checks++; if (dco_code !== 13'd998) begin errors++; $display("FAIL rl_w2: got %0d want 998", dco_code); end
        m_offset = 0;
        wait_meas(1, "rl");
`ifdef FLL_RELOCK_EN
        checks++; if (dco_code !== 13'd4096 || busy !== 1'b1) begin errors++;
            $display("FAIL rl_restart: got code=%0d busy=%b want 4096, 1", dco_code, busy); end
        wait_meas(13, "rl");
        checks++; if (dco_code !== 13'd1000) begin errors++; $display("FAIL rl_reacquired: got %0d want 1000", dco_code); end
`else
        checks++; if (dco_code !== 13'd997) begin errors++; $display("FAIL rl_tracking: got %0d want 997", dco_code); end
        wait_meas(2, "rl");
        checks++; if (dco_code !== 13'd998) begin errors++; $display("FAIL rl_track_settle: got %0d want 998", dco_code); end
`endif
        checks++; if (ll_seen - ll0 !== 1) begin errors++; $display("FAIL rl_lost_count: got %0d want 1", ll_seen - ll0); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_deadband();
        test_saturation();
        test_abort();
        test_reset_midop();
        test_relock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
